// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the slice-serial adder/subtractor.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // A one-slice operation still needs a 1-bit counter so the FSM logic stays uniform.
   function automatic int cnt_width(input int s);
      return (s > 1) ? $clog2(s) : 1;
   endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand and result handshake bundle for serial_addsub.
interface serial_addsub_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;

   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_result, out_cout, out_ovf, out_zero
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_result, out_cout, out_ovf, out_zero
   );
endinterface

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder; the unit cell of the per-cycle ripple chain.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle A+B / A-B: SLICE bits per cycle through a full-adder chain,
// with carry, signed-overflow and zero flags.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input logic            clk,
   input logic            rst,
   serial_addsub_if.slave bus
);

   localparam int S  = WIDTH / SLICE;
   localparam int CW = cnt_width(S);

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   logic [SLICE:0]   c;
   logic [SLICE-1:0] sum;
   logic [WIDTH-1:0] res_next;

   assign c[0] = carry_q;

   for (genvar i = 0; i < SLICE; i++) begin : g_chain
      fa_cell u_fa (
         .a   (a_q[i]),
         .b   (b_q[i]),
         .cin (c[i]),
         .sum (sum[i]),
         .cout(c[i+1])
      );
   end

   // Sum bits enter at the top, so after S slices the LSB slice sits at bit 0.
   assign res_next = (res_q >> SLICE) | (WIDTH'(sum) << (WIDTH - SLICE));

   // NOTE: every register here uses <= so all of them update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.in_a;
                  b_q        <= (bus.in_sub == OP_SUB) ? ~bus.in_b : bus.in_b;
                  carry_q    <= bus.in_sub;
                  cnt_q      <= CW'(S - 1);
                  state      <= BUSY;
                  in_ready_q <= 1'b0;
               end
            end
            BUSY: begin
               a_q     <= a_q >> SLICE;
               b_q     <= b_q >> SLICE;
               res_q   <= res_next;
               carry_q <= c[SLICE];
               if (cnt_q == '0) begin
                  cout_q      <= c[SLICE];
                  ovf_q       <= c[SLICE-1] ^ c[SLICE];
                  zero_q      <= ~|res_next;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = res_q;
   assign bus.out_cout   = cout_q;
   assign bus.out_ovf    = ovf_q;
   assign bus.out_zero   = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=8/SLICE=1 and WIDTH=16/SLICE=4.
module tb_serial_addsub;
   import serial_addsub_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   serial_addsub_if #(.WIDTH(8))  if8 ();
   serial_addsub_if #(.WIDTH(16)) if16 ();

   serial_addsub #(.WIDTH(8), .SLICE(1)) u_dut8 (
      .clk(clk), .rst(rst), .bus(if8)
   );
   serial_addsub #(.WIDTH(16), .SLICE(4)) u_dut16 (
      .clk(clk), .rst(rst), .bus(if16)
   );

   // Drive an operand set at a negedge; returns at the negedge after the accepting edge.
   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sub);
      if8.in_a = a; if8.in_b = b; if8.in_sub = sub; if8.in_valid = 1'b1;
      @(negedge clk);
      if8.in_valid = 1'b0;
   endtask

   task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic sub);
      if16.in_a = a; if16.in_b = b; if16.in_sub = sub; if16.in_valid = 1'b1;
      @(negedge clk);
      if16.in_valid = 1'b0;
   endtask

   // Counts edges from acceptance until out_valid is seen; -1 on timeout.
   task automatic wait8(output int lat);
      lat = 0;
      while (!if8.out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!if8.out_valid) lat = -1;
   endtask

   task automatic wait16(output int lat);
      lat = 0;
      while (!if16.out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!if16.out_valid) lat = -1;
   endtask

   task automatic take8();
      if8.out_ready = 1'b1;
      @(negedge clk);
      if8.out_ready = 1'b0;
   endtask

   task automatic take16();
      if16.out_ready = 1'b1;
      @(negedge clk);
      if16.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (if8.in_ready !== 1'b1) $display("FAIL rst8_in_ready: got %b want 1", if8.in_ready); else passed++;
      total++; if (if8.out_valid !== 1'b0) $display("FAIL rst8_out_valid: got %b want 0", if8.out_valid); else passed++;
      total++; if (if8.out_result !== 8'h00) $display("FAIL rst8_result: got %h want 00", if8.out_result); else passed++;
      total++; if ({if8.out_cout, if8.out_ovf, if8.out_zero} !== 3'b000)
         $display("FAIL rst8_flags: got %b want 000", {if8.out_cout, if8.out_ovf, if8.out_zero}); else passed++;
      total++; if (if16.in_ready !== 1'b1) $display("FAIL rst16_in_ready: got %b want 1", if16.in_ready); else passed++;
      total++; if ({if16.out_valid, if16.out_cout, if16.out_ovf, if16.out_zero} !== 4'b0000)
         $display("FAIL rst16_outs: got %b want 0000", {if16.out_valid, if16.out_cout, if16.out_ovf, if16.out_zero}); else passed++;
      total++; if (if16.out_result !== 16'h0000) $display("FAIL rst16_result: got %h want 0000", if16.out_result); else passed++;
   endtask

   // One full 8-bit operation against hand-computed results.
   task automatic test_op8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic sub,
                           input logic [7:0] er, input logic ec, input logic eo, input logic ez);
      int lat;
      total++; if (if8.in_ready !== 1'b1) $display("FAIL %s_ready: got %b want 1", nm, if8.in_ready); else passed++;
      start8(a, b, sub);
      wait8(lat);
      total++; if (lat !== 8) $display("FAIL %s_latency: got %0d want 8", nm, lat); else passed++;
      total++; if (if8.out_result !== er) $display("FAIL %s_result: got %h want %h", nm, if8.out_result, er); else passed++;
      total++; if ({if8.out_cout, if8.out_ovf, if8.out_zero} !== {ec, eo, ez})
         $display("FAIL %s_flags(c,o,z): got %b want %b", nm, {if8.out_cout, if8.out_ovf, if8.out_zero}, {ec, eo, ez});
      else passed++;
      take8();
      total++; if (if8.in_ready !== 1'b1) $display("FAIL %s_ready_after: got %b want 1", nm, if8.in_ready); else passed++;
   endtask

   task automatic test_backpressure();
      int lat;
      start8(8'd10, 8'd20, OP_ADD);
      wait8(lat);
      if8.in_a = 8'd1; if8.in_b = 8'd1; if8.in_sub = OP_ADD; if8.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (if8.out_result !== 8'd30 || if8.out_valid !== 1'b1)
            $display("FAIL hold_result[%0d]: got %h/%b want 1e/1", i, if8.out_result, if8.out_valid); else passed++;
         total++; if (if8.in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d]: got %b want 0", i, if8.in_ready); else passed++;
      end
      if8.out_ready = 1'b1;
      @(negedge clk);
      if8.out_ready = 1'b0;
      total++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0)
         $display("FAIL hold_release: got ready=%b valid=%b want 1/0", if8.in_ready, if8.out_valid); else passed++;
      start8(8'd1, 8'd1, OP_ADD);
      wait8(lat);
      total++; if (lat !== 8) $display("FAIL hold_next_latency: got %0d want 8", lat); else passed++;
      total++; if (if8.out_result !== 8'd2) $display("FAIL hold_next_result: got %h want 02", if8.out_result); else passed++;
      take8();
   endtask

   task automatic test_abort();
      int lat;
      start8(8'd50, 8'd60, OP_ADD);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0)
         $display("FAIL abort_hs: got ready=%b valid=%b want 1/0", if8.in_ready, if8.out_valid); else passed++;
      total++; if ({if8.out_result, if8.out_cout, if8.out_ovf, if8.out_zero} !== 11'd0)
         $display("FAIL abort_outs: got %h %b%b%b want 00 000", if8.out_result, if8.out_cout, if8.out_ovf, if8.out_zero); else passed++;
      start8(8'd3, 8'd4, OP_ADD);
      wait8(lat);
      total++; if (lat !== 8) $display("FAIL abort_next_latency: got %0d want 8", lat); else passed++;
      total++; if (if8.out_result !== 8'd7) $display("FAIL abort_next_result: got %h want 07", if8.out_result); else passed++;
      take8();
   endtask

   task automatic test_wide();
      int lat;
      start16(16'hFFFF, 16'h0001, OP_ADD);
      wait16(lat);
      total++; if (lat !== 4) $display("FAIL w16_latency: got %0d want 4", lat); else passed++;
      total++; if (if16.out_result !== 16'h0000) $display("FAIL w16_result: got %h want 0000", if16.out_result); else passed++;
      total++; if ({if16.out_cout, if16.out_ovf, if16.out_zero} !== 3'b101)
         $display("FAIL w16_flags(c,o,z): got %b want 101", {if16.out_cout, if16.out_ovf, if16.out_zero}); else passed++;
      take16();
   endtask

   task automatic test_back_to_back();
      logic [15:0] opa [3] = '{16'h1234, 16'h8000, 16'h00FF};
      logic [15:0] opb [3] = '{16'h0001, 16'h0001, 16'hFF01};
      logic        ops [3] = '{OP_ADD, OP_SUB, OP_ADD};
      logic [15:0] exp [3] = '{16'h1235, 16'h7FFF, 16'h0000};
      int idx = 0, nres = 0, last = -1;
      if16.out_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && nres < 3; cyc++) begin
         @(negedge clk);
         if (if16.out_valid) begin
            total++; if (if16.out_result !== exp[nres])
               $display("FAIL b2b_result[%0d]: got %h want %h", nres, if16.out_result, exp[nres]); else passed++;
            nres++;
         end
         if (if16.in_ready && idx < 3) begin
            if (last >= 0) begin
               total++; if (cyc - last !== 6) $display("FAIL b2b_interval[%0d]: got %0d want 6", idx, cyc - last); else passed++;
            end
            last = cyc;
            if16.in_a = opa[idx]; if16.in_b = opb[idx]; if16.in_sub = ops[idx]; if16.in_valid = 1'b1;
            idx++;
         end else begin
            if16.in_valid = 1'b0;
         end
      end
      total++; if (nres !== 3) $display("FAIL b2b_timeout: got %0d results want 3", nres); else passed++;
      if16.out_ready = 1'b0;
      if16.in_valid  = 1'b0;
   endtask

   initial begin
      if8.in_valid = 1'b0;  if8.in_a = '0;  if8.in_b = '0;  if8.in_sub = 1'b0;  if8.out_ready = 1'b0;
      if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_sub = 1'b0; if16.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_op8("add_100_27", 8'd100, 8'd27, OP_ADD, 8'd127, 1'b0, 1'b0, 1'b0);
      test_op8("add_7f_01",  8'h7F,  8'h01, OP_ADD, 8'h80,  1'b0, 1'b1, 1'b0);
      test_op8("add_ff_01",  8'hFF,  8'h01, OP_ADD, 8'h00,  1'b1, 1'b0, 1'b1);
      test_op8("sub_5_9",    8'd5,   8'd9,  OP_SUB, 8'hFC,  1'b0, 1'b0, 1'b0);
      test_op8("sub_9_9",    8'd9,   8'd9,  OP_SUB, 8'h00,  1'b1, 1'b0, 1'b1);
      test_op8("sub_80_01",  8'h80,  8'h01, OP_SUB, 8'h7F,  1'b1, 1'b1, 1'b0);
      test_backpressure();
      test_abort();
      test_wide();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle adder/subtractor that computes A+B or A−B over WIDTH/SLICE clock cycles by rippling carry through a SLICE-bit chain of full-adder cells. Operands enter and results leave through valid/ready handshakes. It is the area-optimised successor to the single-bit combinational add/subtract cells and is used wherever wide arithmetic must run without a full-width ripple chain. It also reports carry/borrow, signed overflow and zero flags.

## Interface
- WIDTH, 8, operand/result width in bits; ≥2.
- SLICE, 1, bits processed per cycle; ≥1, must divide WIDTH.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- out_cout  out  1  carry out of MSB. For subtraction, 1 means no borrow.
- out_ovf  out  1  signed (two's-complement) overflow.
- out_zero  out  1  out_result == 0.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset forces IDLE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid, capture in_a and in_b. When in_sub = 1, capture ~in_b instead of in_b.
  - Set carry register to in_sub and slice counter to S−1, where S = WIDTH/SLICE.
  - Go to BUSY.
- **BUSY:**
  - in_ready = 0.
  - Each cycle, feed the low SLICE bits of the A/B shift registers plus the carry register through the fa_cell chain.
  - Shift the SLICE sum bits into the top of the result register, and shift A/B right by SLICE.
  - Load the carry register with the chain carry-out.
  - On the cycle where counter == 0, also latch the carry into the MSB cell (for overflow) and go to DONE. Otherwise decrement the counter.
- **DONE:**
  - out_valid = 1. out_result and flags are held stable.
  - On out_ready, go to IDLE.
  - in_ready = 0 throughout; in_valid is ignored.
- **Flags:**
  - out_cout = final carry.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero = ~|out_result.
- **Reset behaviour:**
  - Every output goes low after reset: out_valid, out_result, out_cout, out_ovf, out_zero.
  - in_ready = 1 after reset.
  - Reset in any state aborts the operation immediately; no partial result is ever presented.
- Input operand bits are don't-care unless in_valid && in_ready.

## Timing
- Acceptance edge is E0 (in_valid && in_ready).
- Slices are processed on edges E1..ES.
- out_valid is high from the cycle after ES, i.e. latency S cycles from acceptance.
- Output handshake at edge EH (out_valid && out_ready); in_ready = 1 from the cycle after EH.
- Minimum initiation interval is S+2 cycles, with out_ready tied high.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to either.
- Reset asserted on any edge: state is IDLE in the following cycle.

## Structure
- **Package serial_addsub_pkg:**
  - State enum: IDLE, BUSY, DONE.
  - Op constants: OP_ADD = 1'b0, OP_SUB = 1'b1.
- **Sub-module fa_cell:**
  - One-bit full adder: a, b, cin → sum, cout.
  - Instantiated SLICE times in a generate loop as a ripple chain.
  - The cell feeding the MSB exposes its cin for the overflow flag.
- Top level contains the FSM, the counter (width $clog2(S), minimum 1), and the A/B/result shift registers.

## Test plan
1. WIDTH=8, SLICE=1: add 100 + 27 → out_result = 127, cout = 0, ovf = 0, zero = 0; out_valid rises exactly 8 cycles after acceptance.
2. Add 8'h7F + 8'h01 → 8'h80, cout = 0, ovf = 1. Then add 8'hFF + 8'h01 → 8'h00, cout = 1, ovf = 0, zero = 1.
3. Sub 5 − 9 → 8'hFC, cout = 0 (borrow), ovf = 0. Then sub 9 − 9 → 8'h00, cout = 1, zero = 1. Then sub 8'h80 − 8'h01 → 8'h7F, ovf = 1.
4. Hold out_ready low for 5 cycles in DONE while driving in_valid with new operands:
   - result stays stable and in_ready stays 0;
   - new operands are not accepted until the cycle after the output handshake.
5. Assert rst during the 3rd BUSY cycle: next cycle shows in_ready = 1, out_valid = 0 and zero outputs. A following 3 + 4 completes correctly (7) with full latency.
6. WIDTH=16, SLICE=4: add 16'hFFFF + 16'h0001 → 16'h0000, cout = 1, zero = 1, latency 4. Then run back-to-back ops with out_ready tied high and confirm an initiation interval of 6 cycles.
